// File: rtl/adc344x_lvds_tx.sv
// ADC344x serial LVDS output emulator: serialises parallel sample words onto
// 1- or 2-wire lanes per channel with DCLK/FCLK, test patterns and bit-slip.
// One bit slot per SysClk cycle; DDR/differential primitives live outside.
module adc344x_lvds_tx #(
  parameter int C_AdcChnls   = 2,
  parameter int C_AdcWireInt = 2,
  parameter int C_AdcBits    = 14
) (
  input  logic                               SysClk,
  input  logic                               SysRst,
  input  logic                               TxEna,
  input  logic [1:0]                         TxPattern,
  input  logic                               TxSlip,
  input  logic [C_AdcChnls*C_AdcBits-1:0]    SmplData,
  input  logic                               SmplValid,
  output logic                               SmplReady,
  output logic                               DclkOut,
  output logic                               FclkOut,
  output logic [C_AdcChnls*C_AdcWireInt-1:0] DataOut,
  output logic                               FrameStart,
  output logic                               Underrun
);

  localparam int N  = C_AdcBits / C_AdcWireInt;
  localparam int H  = (N + 1) / 2;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int L  = C_AdcChnls * C_AdcWireInt;
  localparam logic [SW-1:0] LAST = SW'(N - 1);
  localparam logic [C_AdcBits-1:0] RAMP_ONE = {{(C_AdcBits-1){1'b0}}, 1'b1};

  logic [SW-1:0]                          r_slot_cnt;
  logic [SW-1:0]                          w_slot_nxt;
  logic [C_AdcChnls-1:0][C_AdcBits-1:0]   r_shift;
  logic [C_AdcChnls-1:0][C_AdcBits-1:0]   w_word;
  logic [C_AdcBits-1:0]                   r_ramp;
  logic [C_AdcBits-1:0]                   w_pat;
  logic                                   w_load;
  logic [L-1:0]                           r_data;
  logic [L-1:0]                           w_load_bits;
  logic [L-1:0]                           w_shift_bits;
  logic                                   r_dclk;
  logic                                   r_fclk;
  logic                                   r_fstart;
  logic                                   r_underrun;

  // Load decision and next slot index
  always_comb begin
    w_load     = (r_slot_cnt == LAST) && TxEna && !TxSlip;
    w_slot_nxt = r_slot_cnt + SW'(1);
  end

  assign SmplReady = w_load && (TxPattern == 2'd0) && !SysRst;

  // Frame word selection for the next load, per channel
  always_comb begin
    w_pat = '0;
    case (TxPattern)
      2'd1: w_pat = r_ramp;
      2'd2: for (int i = 0; i < C_AdcBits; i++) w_pat[i] = ((C_AdcBits - 1 - i) % 2 == 0);
      2'd3: for (int i = 0; i < C_AdcBits; i++) w_pat[i] = (i >= C_AdcBits - C_AdcBits / 2);
      default: w_pat = '0;
    endcase
    for (int c = 0; c < C_AdcChnls; c++) begin
      if (TxPattern == 2'd0)
        w_word[c] = SmplValid ? SmplData[c*C_AdcBits +: C_AdcBits] : '0;
      else
        w_word[c] = w_pat;
    end
  end

  // Lane bits: lane j of a channel takes word bit (MSB - j) of the current slot
  always_comb begin
    w_load_bits  = '0;
    w_shift_bits = '0;
    for (int c = 0; c < C_AdcChnls; c++) begin
      for (int j = 0; j < C_AdcWireInt; j++) begin
        w_load_bits[c*C_AdcWireInt + j]  = w_word[c][C_AdcBits-1-j];
        w_shift_bits[c*C_AdcWireInt + j] = r_shift[c][C_AdcBits-1-j];
      end
    end
  end

  // Slot counter, shift registers, ramp and registered serial outputs
  always_ff @(posedge SysClk) begin
    if (SysRst) begin
      r_slot_cnt <= LAST;
      r_shift    <= '0;
      r_ramp     <= '0;
      r_data     <= '0;
      r_dclk     <= 1'b0;
      r_fclk     <= 1'b0;
      r_fstart   <= 1'b0;
      r_underrun <= 1'b0;
    end else if (!TxEna) begin
      // abandon any partial frame; ramp and underrun are kept
      r_slot_cnt <= LAST;
      r_shift    <= '0;
      r_data     <= '0;
      r_dclk     <= 1'b0;
      r_fclk     <= 1'b0;
      r_fstart   <= 1'b0;
    end else if (TxSlip) begin
      // hold the slot so every output repeats; only the bit clock moves on
      r_dclk   <= !r_dclk;
      r_fstart <= 1'b0;
    end else if (w_load) begin
      r_slot_cnt <= '0;
      for (int c = 0; c < C_AdcChnls; c++) r_shift[c] <= w_word[c] << C_AdcWireInt;
      r_data     <= w_load_bits;
      r_dclk     <= !r_dclk;
      r_fclk     <= (H > 0);
      r_fstart   <= 1'b1;
      if (TxPattern == 2'd1) r_ramp <= r_ramp + RAMP_ONE;
      if ((TxPattern == 2'd0) && !SmplValid) r_underrun <= 1'b1;
    end else begin
      r_slot_cnt <= w_slot_nxt;
      for (int c = 0; c < C_AdcChnls; c++) r_shift[c] <= r_shift[c] << C_AdcWireInt;
      r_data     <= w_shift_bits;
      r_dclk     <= !r_dclk;
      r_fclk     <= (int'(w_slot_nxt) < H);
      r_fstart   <= 1'b0;
    end
  end

  assign DataOut    = r_data;
  assign DclkOut    = r_dclk;
  assign FclkOut    = r_fclk;
  assign FrameStart = r_fstart;
  assign Underrun   = r_underrun;

endmodule

// File: tb/tb_adc344x_lvds_tx.sv
// Bench for adc344x_lvds_tx: fixed vector table, directed multi-cycle
// sequences (slip, underrun, disable, ramp/deskew/sync, ramp wrap on a
// narrow 1-wire instance) and random stimulus against a reference model.
module tb_adc344x_lvds_tx;

  localparam int CH = 2;
  localparam int W  = 2;
  localparam int B  = 14;
  localparam int N  = B / W;
  localparam int H  = (N + 1) / 2;
  localparam int L  = CH * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en, slip, valid;
  logic [1:0]      pat;
  logic [CH*B-1:0] data;
  logic            ready, dclk, fclk, fstart, under;
  logic [L-1:0]    dout;

  adc344x_lvds_tx #(.C_AdcChnls(CH), .C_AdcWireInt(W), .C_AdcBits(B)) dut (
    .SysClk(clk), .SysRst(rst), .TxEna(en), .TxPattern(pat), .TxSlip(slip),
    .SmplData(data), .SmplValid(valid), .SmplReady(ready), .DclkOut(dclk),
    .FclkOut(fclk), .DataOut(dout), .FrameStart(fstart), .Underrun(under));

  // narrow 1-wire single-channel instance, used for the ramp wrap
  logic       rst2, en2, slip2, valid2;
  logic [1:0] pat2;
  logic [3:0] data2;
  logic       ready2, dclk2, fclk2, fstart2, under2;
  logic [0:0] dout2;

  adc344x_lvds_tx #(.C_AdcChnls(1), .C_AdcWireInt(1), .C_AdcBits(4)) dut2 (
    .SysClk(clk), .SysRst(rst2), .TxEna(en2), .TxPattern(pat2), .TxSlip(slip2),
    .SmplData(data2), .SmplValid(valid2), .SmplReady(ready2), .DclkOut(dclk2),
    .FclkOut(fclk2), .DataOut(dout2), .FrameStart(fstart2), .Underrun(under2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_slot = N - 1;
  logic [B-1:0] m_word [CH];
  logic [B-1:0] m_ramp = '0;
  bit         m_under = 0;
  bit         m_dclk = 0;
  bit         m_first = 0;
  bit         seen_ready;

  function automatic logic [B-1:0] frame_word(input logic [1:0] p, input bit v,
                                              input logic [CH*B-1:0] d, input int c);
    int unsigned x;
    x = 0;
    case (p)
      2'd0: x = v ? int'(d[c*B +: B]) : 0;
      2'd1: x = int'(m_ramp);
      2'd2: for (int k = 0; k < B; k += 2) x = x + (1 << (B - 1 - k));
      default: x = ((1 << B) - 1) - ((1 << (B - B / 2)) - 1);
    endcase
    return B'(x);
  endfunction

  function automatic logic [L-1:0] exp_lanes();
    logic [L-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      for (int j = 0; j < W; j++)
        r[c*W + j] = m_word[c][B - 1 - (m_slot * W + j)];
    return r;
  endfunction

  task automatic cycle(input bit r, input bit e, input bit s, input bit v,
                       input logic [1:0] p, input logic [CH*B-1:0] d);
    bit load;
    rst = r; en = e; slip = s; valid = v; pat = p; data = d;
    #1;
    load = !r && e && !s && (m_slot == N - 1);
    seen_ready = ready;
    chk("ready", 32'(ready), 32'(load && (p == 2'd0)));
    @(posedge clk); #1;
    if (r) begin
      m_slot = N - 1; m_ramp = '0; m_under = 0; m_dclk = 0; m_first = 0;
      for (int c = 0; c < CH; c++) m_word[c] = '0;
    end else if (!e) begin
      m_slot = N - 1; m_dclk = 0; m_first = 0;
      for (int c = 0; c < CH; c++) m_word[c] = '0;
    end else if (s) begin
      m_dclk = !m_dclk; m_first = 0;
    end else begin
      m_dclk = !m_dclk;
      if (load) begin
        for (int c = 0; c < CH; c++) m_word[c] = frame_word(p, v, d, c);
        if (p == 2'd1) m_ramp = m_ramp + 1'b1;
        if (p == 2'd0 && !v) m_under = 1;
        m_slot = 0; m_first = 1;
      end else begin
        m_slot++; m_first = 0;
      end
    end
    chk("dout", 32'(dout), 32'(exp_lanes()));
    chk("dclk", 32'(dclk), 32'(m_dclk));
    chk("fclk", 32'(fclk), 32'(m_slot < H));
    chk("fstart", 32'(fstart), 32'(m_first));
    chk("underrun", 32'(under), 32'(m_under));
  endtask

  // state must be at slot N-1; returns the deserialised words
  task automatic capture_frame(input logic [1:0] p, input bit v, input logic [CH*B-1:0] d,
                               output logic [CH*B-1:0] w);
    w = '0;
    cycle(0, 1, 0, v, p, d);
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < CH; c++)
        for (int j = 0; j < W; j++)
          w[c*B + B - 1 - (k * W + j)] = dout[c*W + j];
      if (k < N - 1) cycle(0, 1, 0, v, p, d);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst, en, slip, valid;
    logic [1:0] pat;
    bit         e_ready;
    logic [3:0] e_dout;
    bit         e_dclk, e_fclk, e_fs, e_under;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [CH*B-1:0] tdata, w;
    int fq[$];
    int rq[$];

    rst = 1; en = 0; slip = 0; valid = 0; pat = 0; data = '0;
    rst2 = 1; en2 = 0; slip2 = 0; valid2 = 0; pat2 = 0; data2 = '0;
    for (int c = 0; c < CH; c++) m_word[c] = '0;

    // ch1 = 0x0001, ch0 = 0x3A5C, then the sync pattern with one slip
    tdata = {14'h0001, 14'h3A5C};
    tbl[0]  = '{1, 1, 0, 1, 2'd0, 0, 4'b0000, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 2'd0, 1, 4'b0011, 1, 1, 1, 0};
    tbl[2]  = '{0, 1, 0, 1, 2'd0, 0, 4'b0001, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 1, 2'd0, 0, 4'b0001, 1, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 1, 2'd0, 0, 4'b0010, 0, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 2'd0, 0, 4'b0010, 1, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 1, 2'd0, 0, 4'b0011, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 1, 2'd0, 0, 4'b1000, 1, 0, 0, 0};
    tbl[8]  = '{0, 1, 0, 1, 2'd3, 0, 4'b1111, 0, 1, 1, 0};
    tbl[9]  = '{0, 1, 1, 1, 2'd3, 0, 4'b1111, 1, 1, 0, 0};
    tbl[10] = '{0, 1, 0, 1, 2'd3, 0, 4'b1111, 0, 1, 0, 0};
    tbl[11] = '{0, 1, 0, 1, 2'd3, 0, 4'b1111, 1, 1, 0, 0};
    tbl[12] = '{0, 1, 0, 1, 2'd3, 0, 4'b0101, 0, 1, 0, 0};
    tbl[13] = '{0, 1, 0, 1, 2'd3, 0, 4'b0000, 1, 0, 0, 0};

    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; slip = tbl[i].slip;
      valid = tbl[i].valid; pat = tbl[i].pat; data = tdata;
      #1;
      chk($sformatf("tbl%0d ready", i), 32'(ready), 32'(tbl[i].e_ready));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d dout", i), 32'(dout), 32'(tbl[i].e_dout));
      chk($sformatf("tbl%0d dclk", i), 32'(dclk), 32'(tbl[i].e_dclk));
      chk($sformatf("tbl%0d fclk", i), 32'(fclk), 32'(tbl[i].e_fclk));
      chk($sformatf("tbl%0d fstart", i), 32'(fstart), 32'(tbl[i].e_fs));
      chk($sformatf("tbl%0d underrun", i), 32'(under), 32'(tbl[i].e_under));
    end

    // ---- slip at slot 3, then slip at slot 6 ----
    cycle(1, 0, 0, 1, 2'd0, tdata);
    for (int i = 0; i < 25; i++) begin
      cycle(0, 1, (i == 4 || i == 15), 1, 2'd0, tdata);
      if (seen_ready) rq.push_back(i);
      if (fstart) fq.push_back(i);
    end
    chk("slip fs count", 32'(fq.size()), 32'd4);
    chk("slip rdy count", 32'(rq.size()), 32'd4);
    if (fq.size() == 4) begin
      chk("slip fs gap1", 32'(fq[1] - fq[0]), 32'd8);
      chk("slip fs gap2", 32'(fq[2] - fq[1]), 32'd8);
      chk("slip fs gap3", 32'(fq[3] - fq[2]), 32'd7);
    end
    if (rq.size() == 4) begin
      chk("slip rdy 2", 32'(rq[2]), 32'd16);
      chk("slip rdy 3", 32'(rq[3]), 32'd23);
    end

    // ---- underrun: sticky until reset ----
    cycle(1, 0, 0, 1, 2'd0, tdata);
    cycle(0, 1, 0, 0, 2'd0, tdata);
    chk("underrun set", 32'(under), 32'd1);
    chk("underrun frame zero", 32'(dout), 32'd0);
    for (int i = 0; i < 13; i++) cycle(0, 1, 0, 1, 2'd0, tdata);
    chk("underrun sticky", 32'(under), 32'd1);
    cycle(1, 1, 0, 1, 2'd0, tdata);
    chk("underrun cleared", 32'(under), 32'd0);

    // ---- disable at slot 2, re-enable with a new sample ----
    cycle(0, 1, 0, 1, 2'd0, tdata);
    cycle(0, 1, 0, 1, 2'd0, tdata);
    cycle(0, 1, 0, 1, 2'd0, tdata);
    cycle(0, 0, 0, 1, 2'd0, tdata);
    chk("dis dout", 32'(dout), 32'd0);
    chk("dis dclk", 32'(dclk), 32'd0);
    chk("dis fclk", 32'(fclk), 32'd0);
    chk("dis fstart", 32'(fstart), 32'd0);
    cycle(0, 1, 0, 1, 2'd0, {14'h2BCD, 14'h1234});
    chk("reen ready", 32'(seen_ready), 32'd1);
    chk("reen fstart", 32'(fstart), 32'd1);
    for (int i = 0; i < N - 1; i++) cycle(0, 1, 0, 1, 2'd0, tdata);

    // ---- ramp, deskew, sync frames ----
    cycle(1, 0, 0, 1, 2'd0, tdata);
    for (int f = 0; f < 3; f++) begin
      capture_frame(2'd1, 1, tdata, w);
      chk($sformatf("ramp%0d ch0", f), 32'(w[B-1:0]), 32'(f));
      chk($sformatf("ramp%0d ch1", f), 32'(w[2*B-1:B]), 32'(f));
    end
    capture_frame(2'd2, 1, tdata, w);
    chk("deskew ch0", 32'(w[B-1:0]), 32'h2AAA);
    chk("deskew ch1", 32'(w[2*B-1:B]), 32'h2AAA);
    capture_frame(2'd3, 1, tdata, w);
    chk("sync ch0", 32'(w[B-1:0]), 32'h3F80);
    chk("sync ch1", 32'(w[2*B-1:B]), 32'h3F80);
    capture_frame(2'd0, 1, {14'h0ABC, 14'h3123}, w);
    chk("sample ch0", 32'(w[B-1:0]), 32'h3123);
    chk("sample ch1", 32'(w[2*B-1:B]), 32'h0ABC);

    // ---- ramp wrap on the 4-bit 1-wire instance ----
    @(posedge clk); #1;
    rst2 = 0; en2 = 1; pat2 = 2'd1;
    for (int f = 0; f < 17; f++) begin
      logic [3:0] w2;
      w2 = '0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        w2[3-k] = dout2[0];
        if (k == 0) chk($sformatf("n4 fstart%0d", f), 32'(fstart2), 32'd1);
      end
      chk($sformatf("n4 ramp%0d", f), 32'(w2), 32'(f % 16));
    end

    // ---- random stimulus against the model ----
    cycle(1, 0, 0, 1, 2'd0, tdata);
    begin
      logic [1:0] rp;
      rp = 2'd0;
      for (int i = 0; i < 800; i++) begin
        logic [CH*B-1:0] rd;
        for (int c = 0; c < CH; c++) rd[c*B +: B] = B'($urandom());
        if ($urandom_range(9) == 0) rp = 2'($urandom_range(3));
        cycle($urandom_range(199) == 0, $urandom_range(19) != 0,
              $urandom_range(15) == 0, $urandom_range(7) != 0, rp, rd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule
